// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: state encodings and iteration count.
package div_unit_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and produce one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract; a set top bit means the divisor did not fit, so restore.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = shifted - {1'b0, dvs};
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider for the E stage.
// state | meaning
// IDLE  | waiting for a request; operands sampled here only
// BUSY  | one restoring step per cycle, WIDTH steps total
// DONE  | result presented with readyE, held while holdE is high
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic             annulE,
  input  logic             holdE,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             div_stallE,
  output logic             readyE,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  localparam logic [5:0] CNT_LOAD = 6'(WIDTH - 1);

  logic [1:0]       state;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             sgn_div;
  logic             sign_a;
  logic             sign_b;

  logic             start_ok;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             neg_a;
  logic             neg_b;

  assign start_ok = (state == IDLE) && startE && !annulE;

  // Stall while a request is being accepted or the divide is running; annul and reset release it at once.
  assign div_stallE = !rst && !annulE && (start_ok || (state == BUSY));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign neg_a = signedE && opa[WIDTH-1];
  assign neg_b = signedE && opb[WIDTH-1];

  // Sign fix-up of the final step; a zero divisor returns all-ones and the original dividend.
  always_comb begin
    q_fix = (sgn_div && (sign_a ^ sign_b)) ? -quo_nx : quo_nx;
    r_fix = (sgn_div && sign_a) ? -rem_nx : rem_nx;
    if (dvs == '0) q_fix = '1;
  end

  // FSM, iteration counter, operand latching and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      sgn_div <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      readyE  <= 1'b0;
      lo_out  <= '0;
      hi_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            rem     <= '0;
            quo     <= neg_a ? -opa : opa;
            dvs     <= neg_b ? -opb : opb;
            sgn_div <= signedE;
            sign_a  <= opa[WIDTH-1];
            sign_b  <= opb[WIDTH-1];
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (annulE) begin
            state <= IDLE;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            if (cnt == '0) begin
              state  <= DONE;
              readyE <= 1'b1;
              lo_out <= q_fix;
              hi_out <= r_fix;
            end else begin
              cnt <= cnt - 6'd1;
            end
          end
        end
        DONE: begin
          if (annulE || !holdE) begin
            state  <= IDLE;
            readyE <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          readyE <= 1'b0;
        end
      endcase
    end
  end

endmodule
